// File: rtl/gpio_cmd_controller.sv
// gpio_cmd_controller: MCU GPIO command decoder driving kernel/image
// loading, run control and EOP handshake for the conv datapath.
module gpio_cmd_controller #(
  parameter int OPC_W    = 3,
  parameter int DATA_W   = 24,
  parameter int KNL_ROWS = 3,
  parameter int ROW_W    = 2,
  parameter int LEN_W    = 10,
  parameter int MCU_W    = 13,
  parameter int GPIO_DW  = 32
) (
  input  logic               i_CLK,
  input  logic               i_rst,
  input  logic [OPC_W-1:0]   i_GPIOctrl,
  input  logic               i_GPIOvalid,
  input  logic [DATA_W-1:0]  i_GPIOdata,
  input  logic               i_EOP_from_FSM,
  input  logic [MCU_W-1:0]   i_MCUdata,
  output logic [GPIO_DW-1:0] o_GPIOdata,
  output logic [DATA_W-1:0]  o_KNLdata,
  output logic [ROW_W-1:0]   o_KNLrow,
  output logic               o_valid_to_CONV,
  output logic               o_valid_to_FSM,
  output logic               o_KNorIMG,
  output logic               o_load,
  output logic               o_run,
  output logic               o_EOP_to_MCU,
  output logic [LEN_W-1:0]   o_imgLength,
  output logic               o_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [ROW_W-1:0] ROW_LAST =
    ROW_W'(KNL_ROWS - 1);

  state_t           state;
  logic             valid_prev;
  logic             strobe;
  logic             kernel_done;
  logic [ROW_W-1:0] row_cnt;
  logic [MCU_W-1:0] mcu_q;

  logic op_knl;
  logic op_size;
  logic op_img;
  logic op_dreq;
  logic op_start;
  logic op_ack;
  logic op_abort;
  logic idle_or_load;
  logic start_ok;
  logic size_zero;

  assign strobe   = i_GPIOvalid & ~valid_prev;
  assign op_knl   = i_GPIOctrl == OPC_W'(0);
  assign op_size  = i_GPIOctrl == OPC_W'(1);
  assign op_img   = i_GPIOctrl == OPC_W'(2);
  assign op_dreq  = i_GPIOctrl == OPC_W'(3);
  assign op_start = i_GPIOctrl == OPC_W'(4);
  assign op_ack   = i_GPIOctrl == OPC_W'(5);
  assign op_abort = i_GPIOctrl == OPC_W'(6);

  assign idle_or_load = (state == IDLE) ||
                        (state == LOAD);
  assign start_ok  = kernel_done &&
                     (o_imgLength != '0);
  assign size_zero = i_GPIOdata[LEN_W-1:0] == '0;

  // Readback bus: state, sticky error, EOP flag and MCU pixel data
  always_comb begin
    o_GPIOdata = '0;
    o_GPIOdata[GPIO_DW-1 -: 2] = state;
    o_GPIOdata[GPIO_DW-3]      = o_err;
    o_GPIOdata[GPIO_DW-4]      = o_EOP_to_MCU;
    o_GPIOdata[MCU_W-1:0]      = mcu_q;
  end

  // Command decode, state machine and all registered outputs
  always_ff @(posedge i_CLK or posedge i_rst) begin
    if (i_rst) begin
      state           <= IDLE;
      valid_prev      <= 1'b0;
      kernel_done     <= 1'b0;
      row_cnt         <= '0;
      mcu_q           <= '0;
      o_KNLdata       <= '0;
      o_KNLrow        <= '0;
      o_valid_to_CONV <= 1'b0;
      o_valid_to_FSM  <= 1'b0;
      o_KNorIMG       <= 1'b1;
      o_load          <= 1'b0;
      o_run           <= 1'b0;
      o_EOP_to_MCU    <= 1'b0;
      o_imgLength     <= '0;
      o_err           <= 1'b0;
    end else begin
      valid_prev      <= i_GPIOvalid;
      mcu_q           <= i_MCUdata;
      o_valid_to_CONV <= 1'b0;
      o_valid_to_FSM  <= 1'b0;
      if (strobe && op_abort) begin
        state        <= IDLE;
        o_load       <= 1'b0;
        o_run        <= 1'b0;
        o_EOP_to_MCU <= 1'b0;
        row_cnt      <= '0;
        kernel_done  <= 1'b0;
        o_err        <= 1'b0;
      end else if (state == RUN) begin
        if (i_EOP_from_FSM) begin
          o_run        <= 1'b0;
          o_EOP_to_MCU <= 1'b1;
          state        <= DONE;
        end
      end else if (strobe) begin
        unique case (1'b1)
          op_knl && idle_or_load: begin
            o_KNorIMG       <= 1'b0;
            o_KNLdata       <= i_GPIOdata;
            o_KNLrow        <= row_cnt;
            o_valid_to_CONV <= 1'b1;
            if (row_cnt == ROW_LAST) begin
              row_cnt     <= '0;
              kernel_done <= 1'b1;
            end else begin
              row_cnt <= row_cnt + ROW_W'(1);
            end
          end
          op_size && (state == IDLE): begin
            if (size_zero)
              o_err <= 1'b1;
            else
              o_imgLength <= i_GPIOdata[LEN_W-1:0];
          end
          op_img && idle_or_load: begin
            o_KNorIMG      <= 1'b1;
            o_load         <= 1'b1;
            o_valid_to_FSM <= 1'b1;
            state          <= LOAD;
          end
          op_start && (state == LOAD): begin
            if (start_ok) begin
              o_load  <= 1'b0;
              o_run   <= 1'b1;
              row_cnt <= '0;
              state   <= RUN;
            end else begin
              o_err <= 1'b1;
            end
          end
          op_ack && (state == DONE): begin
            o_EOP_to_MCU <= 1'b0;
            kernel_done  <= 1'b0;
            state        <= IDLE;
          end
          op_dreq: begin
            o_err <= o_err;
          end
          default: begin
            o_err <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gpio_cmd_controller.sv
// tb_gpio_cmd_controller: directed plus random command stream
// checked against a behavioural model of the command rules.
module tb_gpio_cmd_controller;

  localparam int OPC_W    = 3;
  localparam int DATA_W   = 24;
  localparam int KNL_ROWS = 3;
  localparam int ROW_W    = 2;
  localparam int LEN_W    = 10;
  localparam int MCU_W    = 13;
  localparam int GPIO_DW  = 32;

  logic               i_CLK = 1'b0;
  logic               i_rst = 1'b1;
  logic [OPC_W-1:0]   i_GPIOctrl = '0;
  logic               i_GPIOvalid = 1'b0;
  logic [DATA_W-1:0]  i_GPIOdata = '0;
  logic               i_EOP_from_FSM = 1'b0;
  logic [MCU_W-1:0]   i_MCUdata = '0;
  logic [GPIO_DW-1:0] o_GPIOdata;
  logic [DATA_W-1:0]  o_KNLdata;
  logic [ROW_W-1:0]   o_KNLrow;
  logic               o_valid_to_CONV;
  logic               o_valid_to_FSM;
  logic               o_KNorIMG;
  logic               o_load;
  logic               o_run;
  logic               o_EOP_to_MCU;
  logic [LEN_W-1:0]   o_imgLength;
  logic               o_err;

  gpio_cmd_controller #(
    .OPC_W(OPC_W), .DATA_W(DATA_W),
    .KNL_ROWS(KNL_ROWS), .ROW_W(ROW_W),
    .LEN_W(LEN_W), .MCU_W(MCU_W),
    .GPIO_DW(GPIO_DW)
  ) dut (
    .i_CLK(i_CLK),
    .i_rst(i_rst),
    .i_GPIOctrl(i_GPIOctrl),
    .i_GPIOvalid(i_GPIOvalid),
    .i_GPIOdata(i_GPIOdata),
    .i_EOP_from_FSM(i_EOP_from_FSM),
    .i_MCUdata(i_MCUdata),
    .o_GPIOdata(o_GPIOdata),
    .o_KNLdata(o_KNLdata),
    .o_KNLrow(o_KNLrow),
    .o_valid_to_CONV(o_valid_to_CONV),
    .o_valid_to_FSM(o_valid_to_FSM),
    .o_KNorIMG(o_KNorIMG),
    .o_load(o_load),
    .o_run(o_run),
    .o_EOP_to_MCU(o_EOP_to_MCU),
    .o_imgLength(o_imgLength),
    .o_err(o_err)
  );

  always #5 i_CLK = ~i_CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: 0 idle, 1 load, 2 run, 3 done
  int               m_state;
  int               m_row;
  int               m_krow;
  bit               m_err, m_eop, m_load, m_run;
  bit               m_knimg, m_kdone;
  logic [LEN_W-1:0]  m_len;
  logic [DATA_W-1:0] m_kdata;
  logic [MCU_W-1:0]  m_mcu;

  task automatic model_reset();
    m_state = 0; m_row = 0; m_krow = 0;
    m_err = 0; m_eop = 0; m_load = 0; m_run = 0;
    m_knimg = 1; m_kdone = 0;
    m_len = '0; m_kdata = '0; m_mcu = '0;
  endtask

  task automatic model_cmd(input int op,
                           input logic [DATA_W-1:0] d,
                           input bit eop,
                           output bit pc, output bit pf);
    pc = 0;
    pf = 0;
    if (op == 6) begin
      m_state = 0; m_load = 0; m_run = 0; m_eop = 0;
      m_row = 0; m_kdone = 0; m_err = 0;
    end else if (m_state == 2) begin
      if (eop) begin
        m_run = 0; m_eop = 1; m_state = 3;
      end
    end else begin
      case (op)
        0: if (m_state <= 1) begin
             m_knimg = 0; pc = 1;
             m_kdata = d; m_krow = m_row;
             m_row = (m_row + 1) % KNL_ROWS;
             if (m_row == 0) m_kdone = 1;
           end else m_err = 1;
        1: if (m_state == 0) begin
             if (d[LEN_W-1:0] == 0) m_err = 1;
             else m_len = d[LEN_W-1:0];
           end else m_err = 1;
        2: if (m_state <= 1) begin
             m_knimg = 1; m_load = 1;
             m_state = 1; pf = 1;
           end else m_err = 1;
        3: ;
        4: if (m_state == 1 && m_kdone && m_len != 0) begin
             m_load = 0; m_run = 1;
             m_state = 2; m_row = 0;
           end else m_err = 1;
        5: if (m_state == 3) begin
             m_eop = 0; m_state = 0; m_kdone = 0;
           end else m_err = 1;
        default: m_err = 1;
      endcase
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] g;
    g = '0;
    g[31:30] = m_state[1:0];
    g[29]    = m_err;
    g[28]    = m_eop;
    g[12:0]  = m_mcu;
    chk({tag, ":gpio"}, o_GPIOdata, g);
    chk({tag, ":knimg"}, o_KNorIMG, m_knimg);
    chk({tag, ":load"}, o_load, m_load);
    chk({tag, ":run"}, o_run, m_run);
    chk({tag, ":eop"}, o_EOP_to_MCU, m_eop);
    chk({tag, ":err"}, o_err, m_err);
    chk({tag, ":len"}, o_imgLength, m_len);
    chk({tag, ":kdata"}, o_KNLdata, m_kdata);
    chk({tag, ":krow"}, o_KNLrow, m_krow);
  endtask

  task automatic step();
    logic [MCU_W-1:0] s;
    s = i_MCUdata;
    @(posedge i_CLK);
    #1;
    m_mcu = s;
  endtask

  task automatic cmd(input int op,
                     input logic [DATA_W-1:0] d,
                     input bit eop,
                     input int hold,
                     input string tag);
    bit pc, pf;
    i_GPIOctrl     = OPC_W'(op);
    i_GPIOdata     = d;
    i_GPIOvalid    = 1'b1;
    i_EOP_from_FSM = eop;
    model_cmd(op, d, eop, pc, pf);
    step();
    i_EOP_from_FSM = 1'b0;
    chk({tag, ":conv"}, o_valid_to_CONV, pc);
    chk({tag, ":fsm"}, o_valid_to_FSM, pf);
    check_all(tag);
    for (int i = 1; i < hold; i++) begin
      step();
      chk({tag, ":conv_hold"}, o_valid_to_CONV, 0);
      chk({tag, ":fsm_hold"}, o_valid_to_FSM, 0);
    end
    i_GPIOvalid = 1'b0;
    step();
    chk({tag, ":conv_rel"}, o_valid_to_CONV, 0);
    chk({tag, ":fsm_rel"}, o_valid_to_FSM, 0);
    check_all({tag, ":rel"});
  endtask

  task automatic eop_step(input string tag);
    i_EOP_from_FSM = 1'b1;
    if (m_state == 2) begin
      m_run = 0; m_eop = 1; m_state = 3;
    end
    step();
    i_EOP_from_FSM = 1'b0;
    check_all(tag);
  endtask

  task automatic to_run(input string tag);
    cmd(6, '0, 0, 1, {tag, ":abort"});
    for (int k = 0; k < KNL_ROWS; k++)
      cmd(0, DATA_W'($urandom), 0, 1, {tag, ":knl"});
    cmd(2, '0, 0, 1, {tag, ":img"});
    cmd(4, '0, 0, 1, {tag, ":start"});
    chk({tag, ":run_on"}, o_run, 1);
    chk({tag, ":load_off"}, o_load, 0);
  endtask

  initial begin
    int r, op, h;
    logic [DATA_W-1:0] d;
    model_reset();
    repeat (3) @(posedge i_CLK);
    #1;
    check_all("reset");
    chk("reset:conv", o_valid_to_CONV, 0);
    chk("reset:fsm", o_valid_to_FSM, 0);
    i_rst = 1'b0;
    step();

    cmd(0, 24'h010203, 0, 1, "knl0");
    cmd(0, 24'h040506, 0, 1, "knl1");
    cmd(0, 24'h070809, 0, 1, "knl2");

    cmd(1, 24'd64, 0, 1, "size64");
    cmd(2, '0, 0, 5, "img_hold5");

    cmd(6, '0, 0, 1, "abort_a");
    cmd(0, 24'h111111, 0, 1, "knl_part0");
    cmd(0, 24'h222222, 0, 1, "knl_part1");
    cmd(2, '0, 0, 1, "img_part");
    cmd(4, '0, 0, 1, "start_early");
    chk("start_early:err", o_err, 1);
    chk("start_early:run", o_run, 0);
    cmd(6, '0, 0, 1, "abort_b");
    chk("abort_b:len", o_imgLength, 64);

    eop_step("eop_in_idle");

    to_run("flow1");
    cmd(3, '0, 0, 1, "dreq_run");
    cmd(7, '0, 0, 1, "op7_run");
    eop_step("eop_run");
    chk("eop_run:status", o_GPIOdata[31:30], 3);
    i_MCUdata = 13'h1ABC;
    step();
    check_all("mcu_done");
    chk("mcu_done:data", o_GPIOdata[12:0], 13'h1ABC);
    chk("mcu_done:eopbit", o_GPIOdata[28], 1);
    cmd(5, '0, 0, 1, "ack");

    to_run("flow2");
    cmd(6, '0, 1, 1, "abort_eop");

    to_run("flow3");
    i_rst = 1'b1;
    #1;
    chk("arst:run", o_run, 0);
    model_reset();
    check_all("arst");
    @(posedge i_CLK);
    #1;
    i_rst = 1'b0;
    i_MCUdata = '0;
    step();
    check_all("arst_rel");

    cmd(1, 24'h000400, 0, 1, "size_zero");
    chk("size_zero:err", o_err, 1);
    cmd(6, '0, 0, 1, "abort_c");
    cmd(7, '0, 0, 1, "op7_idle");
    cmd(6, '0, 0, 1, "abort_d");

    for (int n = 0; n < 300; n++) begin
      r  = $urandom_range(0, 10);
      op = (r < 3) ? 0 : r - 3;
      d  = DATA_W'($urandom);
      if (op == 1 && $urandom_range(0, 3) == 0)
        d[LEN_W-1:0] = '0;
      h  = $urandom_range(1, 3);
      i_MCUdata = MCU_W'($urandom);
      cmd(op, d, $urandom_range(0, 3) == 0, h, "rnd");
      if ($urandom_range(0, 4) == 0)
        eop_step("rnd_eop");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
